// File: rtl/fft_frame_ctrl.sv
// Audio-to-FFT frame controller: buffers 64 samples, streams them into an FFT,
// then reorders the bit-reversed FFT output into natural bin indices.
module fft_frame_ctrl #(
  parameter int WIDTH    = 16,
  parameter int WD_LIMIT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] smp_data,
  output logic             smp_ready,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             bin_valid,
  output logic [5:0]       bin_idx,
  output logic [WIDTH-1:0] bin_re,
  output logic [WIDTH-1:0] bin_im,
  output logic             frame_done,
  output logic             overrun,
  output logic             wd_err
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Watchdog fires on the idle cycle that would bring the count to WD_LIMIT.
  localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);

  logic [1:0]       state_q,   state_d;
  logic [5:0]       wr_cnt_q,  wr_cnt_d;
  logic [5:0]       rd_cnt_q,  rd_cnt_d;
  logic [5:0]       bin_cnt_q, bin_cnt_d;
  logic [7:0]       wd_q,      wd_d;
  logic             di_en_q,   di_en_d;
  logic [WIDTH-1:0] di_re_q,   di_re_d;
  logic             bv_q,      bv_d;
  logic [5:0]       idx_q,     idx_d;
  logic [WIDTH-1:0] bre_q,     bre_d;
  logic [WIDTH-1:0] bim_q,     bim_d;
  logic             fd_q,      fd_d;
  logic             ov_q,      ov_d;
  logic             wde_q,     wde_d;

  logic [WIDTH-1:0] buf_q [64];
  logic             smp_accept;

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      r[i] = v[5-i];
    end
    return r;
  endfunction

  assign smp_ready  = (state_q == S_FILL);
  assign smp_accept = smp_ready && smp_valid;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    bin_cnt_d = bin_cnt_q;
    wd_d      = wd_q;
    di_en_d   = 1'b0;
    di_re_d   = di_re_q;
    bv_d      = 1'b0;
    idx_d     = idx_q;
    bre_d     = bre_q;
    bim_d     = bim_q;
    fd_d      = 1'b0;
    wde_d     = 1'b0;
    ov_d      = smp_valid && !smp_ready;

    case (state_q)
      S_FILL: begin
        if (smp_accept) begin
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'd63) begin
            state_d  = S_FEED;
            rd_cnt_d = '0;
          end
        end
      end

      S_FEED: begin
        di_en_d  = 1'b1;
        di_re_d  = buf_q[rd_cnt_q];
        rd_cnt_d = rd_cnt_q + 6'd1;
        if (rd_cnt_q == 6'd63) begin
          state_d   = S_DRAIN;
          bin_cnt_d = '0;
          wd_d      = '0;
        end
      end

      S_DRAIN: begin
        if (fft_do_en) begin
          bv_d      = 1'b1;
          idx_d     = bitrev6(bin_cnt_q);
          bre_d     = fft_do_re;
          bim_d     = fft_do_im;
          bin_cnt_d = bin_cnt_q + 6'd1;
          wd_d      = '0;
          if (bin_cnt_q == 6'd63) begin
            fd_d    = 1'b1;
            state_d = S_FILL;
          end
        end else if (wd_q == WD_LAST) begin
          wde_d     = 1'b1;
          state_d   = S_FILL;
          bin_cnt_d = '0;
          wd_d      = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      bin_cnt_q <= '0;
      wd_q      <= '0;
      di_en_q   <= 1'b0;
      di_re_q   <= '0;
      bv_q      <= 1'b0;
      idx_q     <= '0;
      bre_q     <= '0;
      bim_q     <= '0;
      fd_q      <= 1'b0;
      ov_q      <= 1'b0;
      wde_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      bin_cnt_q <= bin_cnt_d;
      wd_q      <= wd_d;
      di_en_q   <= di_en_d;
      di_re_q   <= di_re_d;
      bv_q      <= bv_d;
      idx_q     <= idx_d;
      bre_q     <= bre_d;
      bim_q     <= bim_d;
      fd_q      <= fd_d;
      ov_q      <= ov_d;
      wde_q     <= wde_d;
    end
  end

  // Sample storage carries no reset; contents are only read after a full refill.
  always_ff @(posedge clock) begin
    if (!reset && smp_accept) begin
      buf_q[wr_cnt_q] <= smp_data;
    end
  end

  assign fft_di_en  = di_en_q;
  assign fft_di_re  = di_re_q;
  assign fft_di_im  = '0;
  assign bin_valid  = bv_q;
  assign bin_idx    = idx_q;
  assign bin_re     = bre_q;
  assign bin_im     = bim_q;
  assign frame_done = fd_q;
  assign overrun    = ov_q;
  assign wd_err     = wde_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl with a frame-level reference model and
// literal checks on ramp ordering, bin reordering, watchdog latency and reset.
module tb_fft_frame_ctrl;

  localparam int W   = 16;
  localparam int WDL = 255;

  logic         clock;
  logic         reset;
  logic         smp_valid;
  logic [W-1:0] smp_data;
  logic         smp_ready;
  logic         fft_di_en;
  logic [W-1:0] fft_di_re;
  logic [W-1:0] fft_di_im;
  logic         fft_do_en;
  logic [W-1:0] fft_do_re;
  logic [W-1:0] fft_do_im;
  logic         bin_valid;
  logic [5:0]   bin_idx;
  logic [W-1:0] bin_re;
  logic [W-1:0] bin_im;
  logic         frame_done;
  logic         overrun;
  logic         wd_err;

  fft_frame_ctrl #(.WIDTH(W), .WD_LIMIT(WDL)) dut (
    .clock(clock), .reset(reset),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_re(bin_re), .bin_im(bin_im),
    .frame_done(frame_done), .overrun(overrun), .wd_err(wd_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = v[i];
    return r;
  endfunction

  // Reference model: phase 0 collecting, 1 streaming to FFT, 2 collecting bins.
  int           m_phase, m_nacc, m_pos, m_bins, m_idle;
  logic [W-1:0] m_frame [64];
  logic [W-1:0] sent_q [$];
  bit           chk_en = 0;
  logic         e_di_en, e_bv, e_fd, e_ov, e_wd;
  logic [W-1:0] e_di_re, e_bre, e_bim;
  logic [5:0]   e_idx;

  int           cyc = 0;
  logic [W-1:0] di_log [$];
  logic [5:0]   bidx_log [$];
  logic [W-1:0] bre_log [$];
  int           fd_cnt, wd_cnt, fd_at_bin, last_do_cyc, wd_cyc;

  task automatic model_step();
    e_di_en = 0; e_bv = 0; e_fd = 0; e_ov = 0; e_wd = 0;
    if (reset) begin
      m_phase = 0; m_nacc = 0; m_pos = 0; m_bins = 0; m_idle = 0;
      e_di_re = '0; e_idx = '0; e_bre = '0; e_bim = '0;
      sent_q.delete();
      return;
    end
    e_ov = smp_valid && (m_phase != 0);
    case (m_phase)
      0: if (smp_valid) begin
        m_frame[m_nacc] = smp_data;
        sent_q.push_back(smp_data);
        m_nacc++;
        if (m_nacc == 64) begin m_nacc = 0; m_phase = 1; m_pos = 0; end
      end
      1: begin
        e_di_en = 1;
        e_di_re = m_frame[m_pos];
        m_pos++;
        if (m_pos == 64) begin m_phase = 2; m_bins = 0; m_idle = 0; end
      end
      default: if (fft_do_en) begin
        e_bv = 1; e_idx = bitrev6(6'(m_bins));
        e_bre = fft_do_re; e_bim = fft_do_im;
        m_bins++; m_idle = 0;
        if (m_bins == 64) begin e_fd = 1; m_phase = 0; m_bins = 0; end
      end else begin
        m_idle++;
        if (m_idle == WDL) begin e_wd = 1; m_phase = 0; m_bins = 0; m_idle = 0; end
      end
    endcase
  endtask

  always @(negedge clock) begin
    cyc++;
    if (chk_en) begin
      check("smp_ready", smp_ready, m_phase == 0);
      check("fft_di_en", fft_di_en, e_di_en);
      if (e_di_en) check("fft_di_re", fft_di_re, e_di_re);
      check("fft_di_im", fft_di_im, '0);
      check("bin_valid", bin_valid, e_bv);
      check("bin_idx", bin_idx, e_idx);
      check("bin_re", bin_re, e_bre);
      check("bin_im", bin_im, e_bim);
      check("frame_done", frame_done, e_fd);
      check("overrun", overrun, e_ov);
      check("wd_err", wd_err, e_wd);
      if (fft_di_en === 1'b1) begin
        if (sent_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_order", fft_di_re, sent_q.pop_front());
        di_log.push_back(fft_di_re);
      end
      if (bin_valid === 1'b1) begin
        bidx_log.push_back(bin_idx);
        bre_log.push_back(bin_re);
      end
      if (frame_done === 1'b1) begin fd_cnt++; fd_at_bin = bidx_log.size(); end
      if (wd_err === 1'b1) begin wd_cnt++; wd_cyc = cyc; end
      if (fft_do_en && m_phase == 2 && !reset) last_do_cyc = cyc;
    end
    if (chk_en || reset) begin
      model_step();
      chk_en = 1;
    end
  end

  task automatic send_frame(input int mode);
    int cnt = 0;
    int guard = 0;
    bit tog = 1;
    while (cnt < 64) begin
      @(posedge clock); #1;
      fft_do_en = 0;
      smp_valid = (mode == 2) ? tog : 1'b1;
      tog = !tog;
      smp_data = (mode == 0) ? W'(cnt) : W'($urandom);
      if (smp_valid && smp_ready) cnt++;
      guard++;
      if (guard > 1000) begin
        check("fill_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic wait_cycles(input int n, input bit valid_hi);
    repeat (n) begin
      @(posedge clock); #1;
      fft_do_en = 0;
      smp_valid = valid_hi;
      smp_data  = W'($urandom);
    end
  endtask

  task automatic drain(input int n, input bit ramp_data, input bit noisy_valid);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
        fft_do_en = 0;
        smp_valid = noisy_valid ? 1'($urandom) : 1'b0;
        smp_data  = W'($urandom);
      end
      @(posedge clock); #1;
      fft_do_en = 1;
      fft_do_re = ramp_data ? W'(i) : W'($urandom);
      fft_do_im = W'($urandom);
      smp_valid = noisy_valid ? 1'($urandom) : 1'b0;
      smp_data  = W'($urandom);
    end
    @(posedge clock); #1;
    fft_do_en = 0;
    smp_valid = 0;
  endtask

  task automatic clear_logs();
    di_log.delete(); bidx_log.delete(); bre_log.delete();
    fd_cnt = 0; wd_cnt = 0; fd_at_bin = 0; last_do_cyc = 0; wd_cyc = 0;
  endtask

  initial begin
    logic [5:0] v;
    reset = 1; smp_valid = 0; smp_data = '0;
    fft_do_en = 0; fft_do_re = '0; fft_do_im = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    v = 6'd1;  check("model_bitrev_1", bitrev6(v), 6'd32);
    v = 6'd3;  check("model_bitrev_3", bitrev6(v), 6'd48);
    v = 6'd62; check("model_bitrev_62", bitrev6(v), 6'd31);

    // Ramp frame with capture-index FFT output.
    clear_logs();
    send_frame(0);
    wait_cycles(70, 0);
    check("ramp_di_count", di_log.size(), 64);
    check("ramp_di_0", di_log[0], 0);
    check("ramp_di_20", di_log[20], 20);
    check("ramp_di_63", di_log[63], 63);
    drain(64, 1, 0);
    wait_cycles(3, 0);
    check("bin_order_0", bidx_log[0], 0);
    check("bin_order_1", bidx_log[1], 32);
    check("bin_order_2", bidx_log[2], 16);
    check("bin_order_3", bidx_log[3], 48);
    check("bin_order_4", bidx_log[4], 8);
    check("bin_order_63", bidx_log[63], 63);
    check("bin_re_5", bre_log[5], 5);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_at_bin", fd_at_bin, 64);

    // Overrun: valid held high through FEED/DRAIN, noisy valid at DRAIN exit.
    send_frame(1);
    wait_cycles(70, 1);
    drain(64, 0, 1);
    wait_cycles(3, 0);

    // Gapped input.
    clear_logs();
    send_frame(2);
    wait_cycles(70, 0);
    check("gapped_di_count", di_log.size(), 64);
    drain(64, 0, 0);
    wait_cycles(3, 0);

    // Watchdog: 10 bins then silence.
    clear_logs();
    send_frame(1);
    wait_cycles(70, 0);
    drain(10, 0, 0);
    wait_cycles(300, 0);
    check("wd_count", wd_cnt, 1);
    check("wd_latency", wd_cyc - last_do_cyc, 256);
    check("wd_no_done", fd_cnt, 0);
    send_frame(1);
    wait_cycles(70, 0);
    drain(64, 0, 0);
    wait_cycles(3, 0);

    // Reset mid-FEED at rd_cnt=20.
    send_frame(1);
    wait_cycles(21, 0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("rst_feed_di_en", fft_di_en, 0);
    check("rst_feed_ready", smp_ready, 1);
    clear_logs();
    send_frame(0);
    wait_cycles(70, 0);
    check("post_rst_di_count", di_log.size(), 64);
    drain(64, 1, 0);
    wait_cycles(3, 0);
    check("post_rst_done", fd_cnt, 1);

    // Reset mid-DRAIN, then a clean frame.
    send_frame(1);
    wait_cycles(70, 0);
    drain(20, 0, 0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("rst_drain_bv", bin_valid, 0);
    wait_cycles(10, 0);
    send_frame(2);
    wait_cycles(70, 0);
    drain(64, 0, 1);
    wait_cycles(5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
